// File: rtl/ahb_lite_rr_master_arbiter_if.sv
// ahb_lite_rr_master_arbiter_if: AHB-Lite master-side bus bundle.
interface ahb_lite_rr_master_arbiter_if;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HWRITE;
  logic        HMASTLOCK;
  logic        HREADY;
  logic        HRESP;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  modport master (
    output HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HWDATA,
    input  HREADY, HRESP, HRDATA
  );
  modport slave (
    input  HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HWDATA,
    output HREADY, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_lite_rr_master_arbiter.sv
// ahb_lite_rr_master_arbiter: round-robin sharing of one AHB-Lite master port
// among NREQ single-transfer requesters, with pipelined address/data phases.
module ahb_lite_rr_master_arbiter #(
  parameter int         NREQ      = 4,
  parameter int         IDW       = $clog2(NREQ),
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic [NREQ-1:0]      req_i,
  input  logic [NREQ-1:0]      req_write_i,
  input  logic [NREQ*32-1:0]   req_addr_i,
  input  logic [NREQ*32-1:0]   req_wdata_i,
  input  logic [NREQ*3-1:0]    req_size_i,
  output logic [NREQ-1:0]      ack_o,
  output logic [NREQ-1:0]      done_o,
  output logic                 err_o,
  output logic [31:0]          rdata_o,
  ahb_lite_rr_master_arbiter_if.master ahb
);
  typedef struct packed {
    logic           v;
    logic [IDW-1:0] id;
    logic [31:0]    addr;
    logic           wr;
    logic [2:0]     size;
    logic [31:0]    wdata;
  } a_t;
  typedef struct packed {
    logic           v;
    logic [IDW-1:0] id;
    logic           wr;
  } d_t;
  logic [NREQ-1:0][31:0] addr_p, wdata_p;
  logic [NREQ-1:0][2:0]  size_p;
  a_t              a_q, a_d;
  d_t              d_q, d_d;
  logic [31:0]     hwdata_q, hwdata_d, rdata_q, rdata_d;
  logic [IDW-1:0]  ptr_q, ptr_d, ab_id_q, ab_id_d, g;
  logic            ab_v_q, ab_v_d, err_q, err_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            efc, load, any, cmp;
  assign addr_p  = req_addr_i;
  assign wdata_p = req_wdata_i;
  assign size_p  = req_size_i;
  assign efc  = d_q.v & ahb.HRESP & ~ahb.HREADY;
  assign load = ahb.HREADY & ~efc;
  assign cmp  = d_q.v & ahb.HREADY;
  // scan downwards so the requester closest after the pointer wins
  always_comb begin
    int j;
    j = 0;
    any = 1'b0;
    g = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      j = int'(ptr_q) + k;
      j = (j >= NREQ) ? j - NREQ : j;
      if (req_i[IDW'(j)]) begin
        any = 1'b1;
        g = IDW'(j);
      end
    end
  end
  always_comb begin
    a_d = a_q;
    d_d = d_q;
    hwdata_d = hwdata_q;
    ptr_d = ptr_q;
    if (load) begin
      d_d = '{v: a_q.v, id: a_q.id, wr: a_q.wr};
      hwdata_d = a_q.wdata;
      a_d.v = any;
      if (any) begin
        a_d = '{v: 1'b1, id: g, addr: addr_p[g], wr: req_write_i[g], size: size_p[g], wdata: wdata_p[g]};
        ptr_d = (int'(g) == NREQ-1) ? '0 : g + IDW'(1);
      end
    end else if (efc) a_d.v = 1'b0;
  end
  // a live completion wins; a cancelled address phase is reported afterwards
  always_comb begin
    done_d = '0;
    err_d = err_q;
    rdata_d = rdata_q;
    ab_v_d = ab_v_q;
    ab_id_d = ab_id_q;
    if (cmp) begin
      done_d[d_q.id] = 1'b1;
      err_d = ahb.HRESP;
      rdata_d = (!d_q.wr && !ahb.HRESP) ? ahb.HRDATA : rdata_q;
    end else if (ab_v_q) begin
      done_d[ab_id_q] = 1'b1;
      err_d = 1'b1;
      ab_v_d = 1'b0;
    end
    if (efc && a_q.v) begin
      ab_v_d = 1'b1;
      ab_id_d = a_q.id;
    end
  end
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      a_q <= '0;
      d_q <= '0;
      hwdata_q <= '0;
      ptr_q <= '0;
      ab_v_q <= 1'b0;
      ab_id_q <= '0;
      done_q <= '0;
      err_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      a_q <= a_d;
      d_q <= d_d;
      hwdata_q <= hwdata_d;
      ptr_q <= ptr_d;
      ab_v_q <= ab_v_d;
      ab_id_q <= ab_id_d;
      done_q <= done_d;
      err_q <= err_d;
      rdata_q <= rdata_d;
    end
  assign ack_o          = (any && load) ? NREQ'(1) << g : '0;
  assign done_o         = done_q;
  assign err_o          = err_q;
  assign rdata_o        = rdata_q;
  assign ahb.HADDR      = a_q.addr;
  assign ahb.HWRITE     = a_q.wr;
  assign ahb.HSIZE      = a_q.size;
  assign ahb.HTRANS     = a_q.v ? 2'b10 : 2'b00;
  assign ahb.HBURST     = 3'b000;
  assign ahb.HPROT      = HPROT_VAL;
  assign ahb.HMASTLOCK  = 1'b0;
  assign ahb.HWDATA     = hwdata_q;
endmodule
